// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, line idle level and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Returns the parity bit a correct frame carries for the given data word.
  function automatic logic uart_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Synchronizes rx_uart, flags synced falling edges and provides a 2-of-3 majority vote
// over the samples taken on the two previous oversample ticks plus the current one.
module uart_bit_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clk_enable,
  input  logic rx_uart,
  output logic line_sync,
  output logic line_fell,
  output logic maj_bit
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic [1:0] samp_q, samp_d;
  logic [2:0] window;

  always_comb begin
    sync_d = {sync_q[0], rx_uart};
    prev_d = sync_q[1];
    samp_d = samp_q;
    if (clk_enable) begin
      samp_d = {samp_q[0], sync_q[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {2{UART_IDLE_LEVEL}};
      prev_q <= UART_IDLE_LEVEL;
      samp_q <= {2{UART_IDLE_LEVEL}};
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      samp_q <= samp_d;
    end
  end

  // The live synced bit is the third sample, so the vote is ready on the deciding tick itself.
  assign window    = {samp_q, sync_q[1]};
  assign line_sync = sync_q[1];
  assign line_fell = prev_q & ~sync_q[1];
  assign maj_bit   = (window[0] & window[1]) | (window[0] & window[2]) | (window[1] & window[2]);

endmodule

// File: rtl/uart_rx_deserializer.sv
// Oversampled UART receive engine: one data word plus error flag per frame, no backpressure.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | line idle, waiting for a synced high->low edge
//   START     | validating the start bit at tick MID+1
//   DATA      | one majority decision per bit period, LSB first
//   PARITY    | checking the parity bit against the received data
//   STOP      | sampling the stop bit and publishing the word
//   WAIT_IDLE | stop bit was low (break); wait for the line to return high
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  input  logic                 parity_en,
  input  logic                 rx_uart,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  output logic                 rx_data_error,
  output logic                 rx_busy
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int TW  = $clog2(OVERSAMPLE) + 1;
  localparam int BW  = $clog2(DATA_BITS) + 1;

  localparam logic [TW-1:0] TICK_START_DEC = TW'(MID + 1);
  localparam logic [TW-1:0] TICK_BIT_DEC   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST       = BW'(DATA_BITS - 1);

  logic line_sync;
  logic line_fell;
  logic maj_bit;

  uart_bit_sync u_bit_sync (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .rx_uart    (rx_uart),
    .line_sync  (line_sync),
    .line_fell  (line_fell),
    .maj_bit    (maj_bit)
  );

  uart_rx_state_e       state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_err_q, par_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    error_d   = error_q;

    unique case (state_q)
      IDLE: begin
        if (line_fell) begin
          state_d   = START;
          tick_d    = '0;
          par_en_d  = parity_en;
          par_err_d = 1'b0;
        end
      end

      START: begin
        if (clk_enable) begin
          if (tick_q == TICK_START_DEC) begin
            if (!maj_bit) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      DATA: begin
        if (clk_enable) begin
          if (tick_q == TICK_BIT_DEC) begin
            tick_d  = '0;
            shift_d = {maj_bit, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
              state_d = par_en_q ? PARITY : STOP;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      PARITY: begin
        if (clk_enable) begin
          if (tick_q == TICK_BIT_DEC) begin
            tick_d    = '0;
            par_err_d = uart_parity(32'(shift_q), PARITY_ODD != 0) != maj_bit;
            state_d   = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      STOP: begin
        if (clk_enable) begin
          if (tick_q == TICK_BIT_DEC) begin
            tick_d  = '0;
            data_d  = shift_q;
            error_d = par_err_q | ~maj_bit;
            valid_d = 1'b1;
            state_d = maj_bit ? IDLE : WAIT_IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      WAIT_IDLE: begin
        // A low stop bit may be a break; never re-arm until the line is released.
        if (line_sync == UART_IDLE_LEVEL) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_data_error = error_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: frames driven bit by bit, expected words
// queued at stimulus time and matched against each rx_data_valid pulse.
module tb_uart_rx_deserializer;

  localparam int BIT_CLKS = 16 * 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_enable = 1'b0;
  logic       parity_en = 1'b0;
  logic       rx_uart = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_error;
  logic       rx_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  int last_valid_cyc = 0;
  logic [8:0] exp_q[$];

  uart_rx_deserializer #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .PARITY_ODD (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .parity_en     (parity_en),
    .rx_uart       (rx_uart),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_error (rx_data_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      clk_enable = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard: every valid pulse must match the oldest queued frame.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rx_data_valid) begin
        pulses++;
        last_valid_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got data=%h err=%b, required no pulse", rx_data, rx_data_error);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (rx_data !== e[7:0]) begin
            errors++;
            $display("FAIL rx_data: got %h, required %h", rx_data, e[7:0]);
          end
          if (rx_data_error !== e[8]) begin
            errors++;
            $display("FAIL rx_data_error: got %b, required %b (data %h)", rx_data_error, e[8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Returns just after a tick posedge, leaving the caller on the following negedge.
  task automatic align_tick(output int t);
    do @(posedge clk); while (!clk_enable);
    #1;
    t = cyc;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic lvl, input bit glitch);
    for (int c = 0; c < BIT_CLKS; c++) begin
      rx_uart = lvl ^ (glitch && c >= 30 && c < 34);
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input bit glitch, input bit drop_pen,
                            input bit align, output int t);
    logic err;
    err = (pen && (((^d) ^ pbit) != 1'b0)) || !stop;
    exp_q.push_back({err, d});
    parity_en = pen;
    t = 0;
    if (align) align_tick(t);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i], glitch);
      if (drop_pen && i == 3) parity_en = ~pen;
    end
    if (pen) send_bit(pbit, 1'b0);
    send_bit(stop, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d frames still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_pulses(input string name, input int base, input int n);
    checks++;
    if (pulses - base !== n) begin
      errors++;
      $display("FAIL %s_pulse_count: got %0d, required %0d", name, pulses - base, n);
    end
  endtask

  task automatic check_busy(input string name, input logic want);
    checks++;
    if (rx_busy !== want) begin
      errors++;
      $display("FAIL %s_busy: got %b, required %b", name, rx_busy, want);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (rx_data_valid !== 1'b0 || rx_data !== 8'h00 || rx_data_error !== 1'b0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_outputs: got valid=%b data=%h err=%b busy=%b, required all 0",
               name, rx_data_valid, rx_data, rx_data_error, rx_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clks(5);
    check_idle_outputs("reset");
    reset = 1'b0;
    wait_clks(100);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_basic();
    int t, base;
    base = pulses;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, t);
    wait_drain("basic");
    check_pulses("basic", base, 1);
    checks++;
    if (last_valid_cyc - t !== 616) begin
      errors++;
      $display("FAIL basic_latency: valid %0d clks after start tick, required 616", last_valid_cyc - t);
    end
    wait_clks(40);
    check_busy("basic_end", 1'b0);
  endtask

  task automatic test_parity();
    int t, base;
    base = pulses;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, t);
    wait_drain("parity_ok");
    checks++;
    if (last_valid_cyc - t !== 680) begin
      errors++;
      $display("FAIL parity_latency: valid %0d clks after start tick, required 680", last_valid_cyc - t);
    end
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, t);
    wait_drain("parity_bad");
    check_pulses("parity", base, 2);
    parity_en = 1'b0;
    wait_clks(40);
  endtask

  task automatic test_reset_mid_frame();
    int t, base;
    base = pulses;
    align_tick(t);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    rx_uart = 1'b1;
    wait_clks(3);
    check_idle_outputs("reset_mid");
    reset = 1'b0;
    wait_clks(200);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, t);
    wait_drain("reset_mid");
    check_pulses("reset_mid", base, 1);
    wait_clks(40);
  endtask

  task automatic test_break();
    int t, base;
    base = pulses;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t);
    rx_uart = 1'b0;
    wait_clks(20 * BIT_CLKS);
    check_busy("break_mid", 1'b1);
    wait_clks(20 * BIT_CLKS);
    check_busy("break_end", 1'b1);
    wait_drain("break");
    rx_uart = 1'b1;
    wait_clks(10);
    check_busy("break_release", 1'b0);
    wait_clks(200);
    check_pulses("break", base, 1);
  endtask

  task automatic test_start_glitch();
    int t, base;
    base = pulses;
    align_tick(t);
    rx_uart = 1'b0;
    wait_clks(12);
    rx_uart = 1'b1;
    wait_clks(8);
    check_busy("glitch_start", 1'b1);
    wait_clks(24);
    check_busy("glitch_reject", 1'b0);
    wait_clks(200);
    check_pulses("glitch", base, 0);
  endtask

  task automatic test_back_to_back();
    int t, base;
    base = pulses;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, t);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, t);
    wait_drain("back_to_back");
    check_pulses("back_to_back", base, 2);
    wait_clks(40);
    check_busy("back_to_back_end", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_reset_mid_frame();
    test_break();
    test_start_glitch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
